// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared constants and FSM state encoding for the data-memory
// controller that sits behind the store buffer.
//
// Optional feature macro: DMEM_CTRL_LD_FLUSH_EN adds the LD_DROP state used to
// absorb read data belonging to a flushed load.
package dmem_ctrl_pkg;

    localparam int RV32_ADDR_WIDTH = 32;
    localparam int RV32_DATA_WIDTH = 32;
    localparam int ROB_TAG_WIDTH   = 6;

    typedef enum logic [2:0] {
        DMEM_ST_IDLE    = 3'd0,
        DMEM_ST_ST_REQ  = 3'd1,
        DMEM_ST_LD_REQ  = 3'd2,
        DMEM_ST_LD_WAIT = 3'd3
`ifdef DMEM_CTRL_LD_FLUSH_EN
        ,
        DMEM_ST_LD_DROP = 3'd4
`endif
    } dmem_state_e;

endpackage

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-port data-memory controller.
// Serialises retiring committed stores and load misses onto one req/gnt memory
// port, returns load data tagged with the ROB tag, and drives the occupy
// back-pressure that gates store-buffer retirement. Exactly one memory
// transaction is outstanding at any time; a store blocks loads until its write
// is granted, which keeps read-after-write order.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_ret_st/_addr/_data       retiring store (already gated by o_dmem_occupy)
//   o_dmem_occupy              controller cannot take a store this cycle
//   i_ld_req/_addr/_tag        load request, accepted when o_ld_rdy
//   o_ld_rdy                   load acceptance
//   o_ld_done/_tag/_data       one-cycle completion pulse with tag and data
//   o_mem_req/_we/_addr/_wdata memory request, held until i_mem_gnt
//   i_mem_gnt                  request accepted (write complete at gnt)
//   i_mem_rvld/_rdata          read data return
//   i_flush                    pipeline flush (only with DMEM_CTRL_LD_FLUSH_EN)
//
// Optional feature macro: DMEM_CTRL_LD_FLUSH_EN enables load flushing; without
// it every accepted load completes.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = RV32_ADDR_WIDTH,
    parameter int DATA_W = RV32_DATA_WIDTH,
    parameter int TAG_W  = ROB_TAG_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ret_st,
    input  logic [ADDR_W-1:0] i_ret_st_addr,
    input  logic [DATA_W-1:0] i_ret_st_data,
    output logic              o_dmem_occupy,
    input  logic              i_ld_req,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [TAG_W-1:0]  i_ld_tag,
    output logic              o_ld_rdy,
    output logic              o_ld_done,
    output logic [TAG_W-1:0]  o_ld_tag,
    output logic [DATA_W-1:0] o_ld_data,
`ifdef DMEM_CTRL_LD_FLUSH_EN
    input  logic              i_flush,
`endif
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvld,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    dmem_state_e       state;
    dmem_state_e       state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [TAG_W-1:0]  tag_q;
    logic              ld_take;
    logic              st_take;
    logic              rd_capture;
    logic              rd_phase;
    logic              flush;

`ifdef DMEM_CTRL_LD_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    // Occupy is built without i_ret_st so the store buffer can gate retirement
    // on it without forming a combinational loop.
    assign o_dmem_occupy = !rst_n || (state != DMEM_ST_IDLE) || i_ld_req;
    assign o_ld_rdy      = (state == DMEM_ST_IDLE) && !flush;
    assign o_mem_req     = (state == DMEM_ST_ST_REQ) || (state == DMEM_ST_LD_REQ);
    assign o_mem_we      = (state == DMEM_ST_ST_REQ);
    assign o_mem_addr    = addr_q;
    assign o_mem_wdata   = wdata_q;

    always_comb begin
        state_nxt  = state;
        ld_take    = 1'b0;
        st_take    = 1'b0;
        rd_capture = 1'b0;
        rd_phase   = 1'b0;
        case (state)
            DMEM_ST_IDLE: begin
                // Loads win same-cycle contention with a retiring store.
                if (i_ld_req && !flush) begin
                    ld_take   = 1'b1;
                    state_nxt = DMEM_ST_LD_REQ;
                end else if (i_ret_st && !i_ld_req) begin
                    st_take   = 1'b1;
                    state_nxt = DMEM_ST_ST_REQ;
                end
            end
            DMEM_ST_ST_REQ: begin
                if (i_mem_gnt) state_nxt = DMEM_ST_IDLE;
            end
            DMEM_ST_LD_REQ: begin
                if (i_mem_gnt) begin
`ifdef DMEM_CTRL_LD_FLUSH_EN
                    state_nxt = flush ? DMEM_ST_LD_DROP : DMEM_ST_LD_WAIT;
`else
                    state_nxt = DMEM_ST_LD_WAIT;
`endif
                end else if (flush) begin
                    state_nxt = DMEM_ST_IDLE;
                end
            end
            DMEM_ST_LD_WAIT: begin
                rd_phase = 1'b1;
                if (i_mem_rvld) begin
                    rd_capture = !flush;
                    state_nxt  = DMEM_ST_IDLE;
                end else if (flush) begin
`ifdef DMEM_CTRL_LD_FLUSH_EN
                    state_nxt = DMEM_ST_LD_DROP;
`endif
                end
            end
`ifdef DMEM_CTRL_LD_FLUSH_EN
            DMEM_ST_LD_DROP: begin
                // Read already granted; swallow its data silently.
                rd_phase = 1'b1;
                if (i_mem_rvld) state_nxt = DMEM_ST_IDLE;
            end
`endif
            default: state_nxt = DMEM_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= DMEM_ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            tag_q     <= '0;
            o_ld_done <= 1'b0;
            o_ld_tag  <= '0;
            o_ld_data <= '0;
        end else begin
            state     <= state_nxt;
            o_ld_done <= rd_capture;
            if (ld_take) begin
                addr_q <= i_ld_addr;
                tag_q  <= i_ld_tag;
            end else if (st_take) begin
                addr_q  <= i_ret_st_addr;
                wdata_q <= i_ret_st_data;
            end
            if (rd_capture) begin
                o_ld_data <= i_mem_rdata;
                o_ld_tag  <= tag_q;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(i_ret_st && o_dmem_occupy))
                else $error("dmem_ctrl: store retired while occupy was high");
            assert (!i_mem_rvld || rd_phase)
                else $error("dmem_ctrl: read data returned with no read outstanding");
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl. A behavioural memory with
// programmable grant and read-data delays serves the port; expected load
// results come from a program-order reference memory and are queued when a
// load is accepted, then popped when o_ld_done pulses.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_ret_st = 1'b0;
    logic [ADDR_W-1:0] i_ret_st_addr = '0;
    logic [DATA_W-1:0] i_ret_st_data = '0;
    logic              o_dmem_occupy;
    logic              i_ld_req = 1'b0;
    logic [ADDR_W-1:0] i_ld_addr = '0;
    logic [TAG_W-1:0]  i_ld_tag = '0;
    logic              o_ld_rdy;
    logic              o_ld_done;
    logic [TAG_W-1:0]  o_ld_tag;
    logic [DATA_W-1:0] o_ld_data;
`ifdef DMEM_CTRL_LD_FLUSH_EN
    logic              i_flush = 1'b0;
`endif
    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic              i_mem_gnt = 1'b0;
    logic              i_mem_rvld = 1'b0;
    logic [DATA_W-1:0] i_mem_rdata = '0;

    dmem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_ret_st(i_ret_st), .i_ret_st_addr(i_ret_st_addr), .i_ret_st_data(i_ret_st_data),
        .o_dmem_occupy(o_dmem_occupy),
        .i_ld_req(i_ld_req), .i_ld_addr(i_ld_addr), .i_ld_tag(i_ld_tag),
        .o_ld_rdy(o_ld_rdy), .o_ld_done(o_ld_done), .o_ld_tag(o_ld_tag), .o_ld_data(o_ld_data),
`ifdef DMEM_CTRL_LD_FLUSH_EN
        .i_flush(i_flush),
`endif
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt), .i_mem_rvld(i_mem_rvld),
        .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } ld_exp_t;

    int                vectors = 0;
    int                miscompares = 0;
    ld_exp_t           sb[$];
    logic [DATA_W-1:0] mem[16];
    logic [DATA_W-1:0] ref_mem[16];
    int                gnt_dly = 0;
    int                rvld_dly = 1;
    int                req_cnt = 0;
    int                rv_cnt = 0;
    bit                rv_pend = 1'b0;
    logic [DATA_W-1:0] rv_data = '0;
    int                done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory: grant after gnt_dly waiting cycles, read data rvld_dly cycles
    // after the read grant; writes land at grant.
    always @(negedge clk) begin
        i_mem_gnt  = 1'b0;
        i_mem_rvld = 1'b0;
        if (!rst_n) begin
            req_cnt = 0;
            rv_pend = 1'b0;
        end else begin
            if (rv_pend) begin
                if (rv_cnt == 0) begin
                    i_mem_rvld  = 1'b1;
                    i_mem_rdata = rv_data;
                    rv_pend     = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end
            if (!o_mem_req) begin
                req_cnt = 0;
            end else if (req_cnt >= gnt_dly) begin
                i_mem_gnt = 1'b1;
                req_cnt   = 0;
                if (o_mem_we) begin
                    mem[o_mem_addr[11:8]] = o_mem_wdata;
                end else begin
                    rv_pend = 1'b1;
                    rv_cnt  = rvld_dly - 1;
                    rv_data = mem[o_mem_addr[11:8]];
                end
            end else begin
                req_cnt++;
            end
        end
    end

    // Completion monitor
    always @(negedge clk) begin
        if (o_ld_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("ld_done_spurious", 64'(o_ld_done), 64'd0);
            end else begin
                ld_exp_t e;
                e = sb.pop_front();
                chk("ld_tag", 64'(o_ld_tag), 64'(e.tag));
                chk("ld_data", 64'(o_ld_data), 64'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Store buffer: retire only in a cycle where occupy is low.
    task automatic retire_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                output bit done_at_accept);
        bit ok = 1'b0;
        done_at_accept = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            i_ret_st = 1'b0;
            #1;
            if (!o_dmem_occupy) begin
                i_ret_st       = 1'b1;
                i_ret_st_addr  = a;
                i_ret_st_data  = d;
                ref_mem[a[11:8]] = d;
                done_at_accept = o_ld_done;
                ok = 1'b1;
            end
        end
        if (!ok) chk("st_retire_timeout", 64'(o_dmem_occupy), 64'd0);
        step();
        i_ret_st = 1'b0;
    endtask

    task automatic issue_load(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t,
                              input bit expect_done, output int waits);
        waits = 0;
        step();
        i_ld_req  = 1'b1;
        i_ld_addr = a;
        i_ld_tag  = t;
        #1;
        while (!o_ld_rdy && waits < 200) begin
            waits++;
            step();
            #1;
        end
        if (!o_ld_rdy) chk("ld_accept_timeout", 64'(o_ld_rdy), 64'd1);
        else if (expect_done) sb.push_back(ld_exp_t'{tag: t, data: ref_mem[a[11:8]]});
        step();
        i_ld_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) step();
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit dflag;
        int w;
        int base;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 32'h1111_1111 * i;
            ref_mem[i] = 32'h1111_1111 * i;
        end
        mem[2]     = 32'h1234_5678;
        ref_mem[2] = 32'h1234_5678;

        // Reset state
        step();
        step();
        chk("rst_occupy", 64'(o_dmem_occupy), 64'd1);
        chk("rst_mem_req", 64'(o_mem_req), 64'd0);
        chk("rst_mem_we", 64'(o_mem_we), 64'd0);
        chk("rst_ld_done", 64'(o_ld_done), 64'd0);
        chk("rst_ld_tag", 64'(o_ld_tag), 64'd0);
        chk("rst_ld_data", 64'(o_ld_data), 64'd0);
        chk("rst_mem_addr", 64'(o_mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(o_mem_wdata), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_occupy", 64'(o_dmem_occupy), 64'd0);
        chk("idle_rdy", 64'(o_ld_rdy), 64'd1);

        // Store alone, grant held off for 3 cycles
        gnt_dly = 3;
        retire_store(32'h100, 32'hDEAD_BEEF, dflag);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("st_req", 64'(o_mem_req), 64'd1);
            chk("st_we", 64'(o_mem_we), 64'd1);
            chk("st_addr", 64'(o_mem_addr), 64'h100);
            chk("st_wdata", 64'(o_mem_wdata), 64'hDEAD_BEEF);
            chk("st_occupy", 64'(o_dmem_occupy), 64'd1);
            chk("st_ld_rdy", 64'(o_ld_rdy), 64'd0);
            step();
        end
        #1;
        chk("st_after_gnt_req", 64'(o_mem_req), 64'd0);
        chk("st_after_gnt_occupy", 64'(o_dmem_occupy), 64'd0);

        // Load with gnt alongside req and rvld two cycles after gnt
        gnt_dly  = 0;
        rvld_dly = 2;
        issue_load(32'h200, 6'd5, 1'b1, w);
        #1;
        chk("ld_req", 64'(o_mem_req), 64'd1);
        chk("ld_we", 64'(o_mem_we), 64'd0);
        chk("ld_addr", 64'(o_mem_addr), 64'h200);
        chk("ld_busy_rdy", 64'(o_ld_rdy), 64'd0);
        step();
        chk("ld_wait_req", 64'(o_mem_req), 64'd0);
        step();
        chk("ld_done_early", 64'(o_ld_done), 64'd0);
        step();
        chk("ld_done_pulse", 64'(o_ld_done), 64'd1);
        chk("ld_done_tag5", 64'(o_ld_tag), 64'd5);
        chk("ld_done_data", 64'(o_ld_data), 64'h1234_5678);
        step();
        chk("ld_done_one_cycle", 64'(o_ld_done), 64'd0);
        drain();

        // Contention: a load and a pending store in the same cycle
        gnt_dly  = 1;
        rvld_dly = 1;
        step();
        i_ld_req  = 1'b1;
        i_ld_addr = 32'h400;
        i_ld_tag  = 6'd7;
        #1;
        chk("cont_occupy", 64'(o_dmem_occupy), 64'd1);
        chk("cont_ld_rdy", 64'(o_ld_rdy), 64'd1);
        sb.push_back(ld_exp_t'{tag: 6'd7, data: ref_mem[4]});
        base = done_cnt;
        step();
        i_ld_req = 1'b0;
        retire_store(32'h500, 32'h0BAD_F00D, dflag);
        chk("cont_st_first_idle", 64'(dflag), 64'd1);
        chk("cont_ld_first", 64'(done_cnt - base), 64'd1);
        drain();

        // RAW: load to the address just stored is held off until the write grant
        gnt_dly = 2;
        retire_store(32'h300, 32'hA5A5_A5A5, dflag);
        issue_load(32'h300, 6'd12, 1'b1, w);
        chk("raw_rdy_blocked", 64'(w != 0), 64'd1);
        drain();
        issue_load(32'h500, 6'd13, 1'b1, w);
        drain();

        // Reset while waiting for read data
        gnt_dly  = 0;
        rvld_dly = 5;
        issue_load(32'h200, 6'd9, 1'b0, w);
        step();
        base  = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("rstmid_occupy", 64'(o_dmem_occupy), 64'd1);
        step();
        chk("rstmid_req", 64'(o_mem_req), 64'd0);
        chk("rstmid_done", 64'(o_ld_done), 64'd0);
        chk("rstmid_idle", 64'(o_ld_rdy), 64'd1);
        chk("rstmid_occupy2", 64'(o_dmem_occupy), 64'd1);
        step();
        rst_n = 1'b1;
        repeat (8) step();
        chk("rstmid_no_done", 64'(done_cnt), 64'(base));

`ifdef DMEM_CTRL_LD_FLUSH_EN
        // Flush in LD_WAIT: read data discarded, next load taken right after
        gnt_dly  = 0;
        rvld_dly = 3;
        issue_load(32'h200, 6'd11, 1'b0, w);
        step();
        i_flush = 1'b1;
        base    = done_cnt;
        step();
        i_flush = 1'b0;
        #1;
        chk("fl_drop_rdy", 64'(o_ld_rdy), 64'd0);
        step();
        chk("fl_rvld_rdy", 64'(o_ld_rdy), 64'd0);
        step();
        chk("fl_after_rvld_rdy", 64'(o_ld_rdy), 64'd1);
        chk("fl_no_done", 64'(o_ld_done), 64'd0);
        i_ld_req  = 1'b1;
        i_ld_addr = 32'h100;
        i_ld_tag  = 6'd13;
        sb.push_back(ld_exp_t'{tag: 6'd13, data: ref_mem[1]});
        step();
        i_ld_req = 1'b0;
        drain();
        chk("fl_done_count", 64'(done_cnt - base), 64'd1);

        // Flush in LD_REQ before grant: request withdrawn
        gnt_dly = 3;
        issue_load(32'h200, 6'd14, 1'b0, w);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        #1;
        chk("fl_req_withdrawn", 64'(o_mem_req), 64'd0);
        chk("fl_req_idle", 64'(o_ld_rdy), 64'd1);
`endif

        // Mixed traffic with varying memory latency
        for (int i = 0; i < 40; i++) begin
            logic [ADDR_W-1:0] a;
            a        = {20'd0, 4'($urandom_range(1, 6)), 8'd0};
            gnt_dly  = $urandom_range(0, 2);
            rvld_dly = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) retire_store(a, $urandom, dflag);
            else issue_load(a, 6'(i), 1'b1, w);
        end
        drain();
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
